// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-control bundle between the hazard/branch logic and the PC stage.
// slave: the PC stage (takes requests, produces the fetch address).
// master: the controller side (issues requests, observes the fetch address).
interface pc_fetch_sequencer_if #(
    parameter int unsigned PC_W = 32
);
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            jump;
    logic [PC_W-1:0] jump_target;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic            pc_valid;
    logic            flush;
    logic            halted;
    logic            misalign_err;

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, resume,
        output pc, pc_valid, flush, halted, misalign_err
    );

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, resume,
        input  pc, pc_valid, flush, halted, misalign_err
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter stage feeding the instruction memory.
// Picks the next PC (branch > jump > stall > +4), pulses flush on redirects,
// stops fetching at HALT_PC and restarts from RESET_PC on resume.
module pc_fetch_sequencer #(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] HALT_PC  = PC_W'(56)
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_fetch_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic [PC_W-1:0] pc_q,       pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            flush_q,    flush_d;
    logic            halted_q,   halted_d;
    logic            misalign_q, misalign_d;

    logic [PC_W-1:0] redirect_tgt;
    logic            redirect;
    logic            advance;
    logic [PC_W-1:0] seq_pc;

    // Next-state and next-PC selection; every output is a flop, so nothing
    // here reaches the ports without passing through a register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        flush_d      = 1'b0;
        halted_d     = halted_q;
        misalign_d   = misalign_q;
        redirect     = 1'b0;
        redirect_tgt = '0;
        advance      = 1'b0;
        seq_pc       = pc_q + PC_W'(4);

        unique case (state_q)
            ST_BOOT: begin
                pc_d       = RESET_PC;
                pc_valid_d = 1'b1;
                halted_d   = 1'b0;
                state_d    = ST_RUN;
            end

            ST_RUN: begin
                if (bus.branch_taken) begin
                    redirect     = 1'b1;
                    redirect_tgt = bus.branch_target;
                end else if (bus.jump) begin
                    redirect     = 1'b1;
                    redirect_tgt = bus.jump_target;
                end

                if (redirect) begin
                    pc_d    = {redirect_tgt[PC_W-1:2], 2'b00};
                    flush_d = 1'b1;
                    advance = 1'b1;
                    if (redirect_tgt[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (!bus.stall) begin
                    pc_d    = seq_pc;
                    advance = 1'b1;
                end

                // A held PC is not a newly loaded address, so only an
                // advancing PC can trigger the halt.
                if (advance && (pc_d == HALT_PC)) begin
                    pc_valid_d = 1'b0;
                    halted_d   = 1'b1;
                    state_d    = ST_HALT;
                end
            end

            ST_HALT: begin
                if (bus.resume) begin
                    pc_d       = RESET_PC;
                    pc_valid_d = 1'b0;
                    halted_d   = 1'b0;
                    state_d    = ST_BOOT;
                end
            end

            default: begin
                pc_d       = RESET_PC;
                pc_valid_d = 1'b0;
                halted_d   = 1'b0;
                state_d    = ST_BOOT;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = pc_valid_q;
    assign bus.flush        = flush_q;
    assign bus.halted       = halted_q;
    assign bus.misalign_err = misalign_q;

endmodule
